// File: rtl/microc_pkg.sv
// Shared constants for the microc sequenced control unit: opcode encodings,
// instruction class masks, ALU op codes, the sequencer state type and counter width.
package microc_pkg;

  localparam int OPC_W    = 6;
  localparam int OP_W     = 3;
  localparam int RETIRE_W = 16;

  localparam logic [OPC_W-1:0] OPC_J    = 6'b110000;
  localparam logic [OPC_W-1:0] OPC_JZ   = 6'b110001;
  localparam logic [OPC_W-1:0] OPC_JNZ  = 6'b110010;
  localparam logic [OPC_W-1:0] OPC_HALT = 6'b111111;

  // Class membership is (Opcode & MASK) == VAL.
  localparam logic [OPC_W-1:0] ALU_MASK = 6'b100000;
  localparam logic [OPC_W-1:0] ALU_VAL  = 6'b000000;
  localparam logic [OPC_W-1:0] LI_MASK  = 6'b110000;
  localparam logic [OPC_W-1:0] LI_VAL   = 6'b100000;

  localparam logic [OP_W-1:0] OP_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } uc_state_t;

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode/z decode into the datapath control word.
// pc_we is not produced here; is_halt lets the sequencer derive it.
module uc_decode
  import microc_pkg::*;
(
  input  logic [OPC_W-1:0] Opcode,
  input  logic             z,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             wez,
  output logic [OP_W-1:0]  Op,
  output logic             is_halt
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    s_inc   = 1'b1;
    s_inm   = 1'b0;
    we3     = 1'b0;
    wez     = 1'b0;
    Op      = OP_NONE;
    is_halt = 1'b0;
    if ((Opcode & ALU_MASK) == ALU_VAL) begin
      Op  = Opcode[4:2];
      we3 = 1'b1;
      wez = 1'b1;
    end else if ((Opcode & LI_MASK) == LI_VAL) begin
      s_inm = 1'b1;
      we3   = 1'b1;
    end else begin
      case (Opcode)
        OPC_J:    s_inc   = 1'b0;
        OPC_JZ:   s_inc   = ~z;
        OPC_JNZ:  s_inc   = z;
        OPC_HALT: is_halt = 1'b1;
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/uc_seq.sv
// Sequenced control unit: BOOT/RUN/HALT state machine around uc_decode.
// Optional retired-instruction counter built when UC_RETIRE_CNT_EN is defined.
module uc_seq
  import microc_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [OPC_W-1:0]    Opcode,
  input  logic                z,
  input  logic                resume,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic [OP_W-1:0]     Op,
  output logic                pc_we,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  uc_state_t       state;
  logic            dec_s_inc, dec_s_inm, dec_we3, dec_wez, dec_is_halt;
  logic [OP_W-1:0] dec_op;

  uc_decode u_decode (
    .Opcode  (Opcode),
    .z       (z),
    .s_inc   (dec_s_inc),
    .s_inm   (dec_s_inm),
    .we3     (dec_we3),
    .wez     (dec_wez),
    .Op      (dec_op),
    .is_halt (dec_is_halt)
  );

  // NOTE: state is sequential, so it is written only with non-blocking
  // assignments; combinational logic below uses blocking ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_BOOT;
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (dec_is_halt) state <= ST_HALT;
        ST_HALT: if (resume) state <= ST_RUN;
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Reset forces the BOOT word regardless of the (possibly unknown) state.
  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    Op     = OP_NONE;
    pc_we  = 1'b0;
    halted = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          s_inc = dec_s_inc;
          s_inm = dec_s_inm;
          we3   = dec_we3;
          wez   = dec_wez;
          Op    = dec_op;
          pc_we = ~dec_is_halt;
        end
        ST_HALT: begin
          halted = 1'b1;
          pc_we  = resume;
        end
        default: ;
      endcase
    end
  end

`ifdef UC_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q;

  // The resume cycle is in HALT, so it never counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (state == ST_RUN && pc_we) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_uc_seq.sv
// Self-checking bench for uc_seq: expected control words are queued when
// stimulus is applied and popped when the outputs are sampled at negedge.
module tb_uc_seq;
  import microc_pkg::*;

  typedef struct packed {
    logic            s_inc;
    logic            s_inm;
    logic            we3;
    logic            wez;
    logic [OP_W-1:0] Op;
    logic            pc_we;
    logic            halted;
  } ctrl_t;

  typedef struct {
    string name;
    ctrl_t ctrl;
    logic  cnt;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset;
  logic [OPC_W-1:0]    opcode;
  logic                z;
  logic                resume;
  logic                s_inc, s_inm, we3, wez, pc_we, halted;
  logic [OP_W-1:0]     op;
  logic [RETIRE_W-1:0] retired;

  exp_t                sb[$];
  logic [RETIRE_W-1:0] exp_cnt = '0;
  int                  checks = 0;
  int                  errors = 0;

  uc_seq dut (
    .clk     (clk),
    .reset   (reset),
    .Opcode  (opcode),
    .z       (z),
    .resume  (resume),
    .s_inc   (s_inc),
    .s_inm   (s_inm),
    .we3     (we3),
    .wez     (wez),
    .Op      (op),
    .pc_we   (pc_we),
    .halted  (halted),
    .retired (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  function automatic ctrl_t c_boot();
    return '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, Op: 3'b000, pc_we: 1'b0, halted: 1'b0};
  endfunction

  function automatic ctrl_t c_alu(input logic [2:0] o);
    return '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b1, wez: 1'b1, Op: o, pc_we: 1'b1, halted: 1'b0};
  endfunction

  function automatic ctrl_t c_li();
    return '{s_inc: 1'b1, s_inm: 1'b1, we3: 1'b1, wez: 1'b0, Op: 3'b000, pc_we: 1'b1, halted: 1'b0};
  endfunction

  function automatic ctrl_t c_jmp(input logic si);
    return '{s_inc: si, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, Op: 3'b000, pc_we: 1'b1, halted: 1'b0};
  endfunction

  function automatic ctrl_t c_halt_run();
    return '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, Op: 3'b000, pc_we: 1'b0, halted: 1'b0};
  endfunction

  function automatic ctrl_t c_halted(input logic res);
    return '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, Op: 3'b000, pc_we: res, halted: 1'b1};
  endfunction

  // One cycle: drive, queue the expectation, sample at negedge, then cross the edge.
  task automatic apply(input string name, input logic rst, input logic [5:0] opc,
                       input logic zz, input logic res, input ctrl_t c, input logic cnt);
    exp_t  e;
    ctrl_t act;
    reset  = rst;
    opcode = opc;
    z      = zz;
    resume = res;
    sb.push_back('{name: name, ctrl: c, cnt: cnt});
    @(negedge clk);
    e   = sb.pop_front();
    act = '{s_inc: s_inc, s_inm: s_inm, we3: we3, wez: wez, Op: op, pc_we: pc_we, halted: halted};
    checks++;
    if (act !== e.ctrl) begin
      errors++;
      $display("FAIL %s ctrl {s_inc,s_inm,we3,wez,Op,pc_we,halted}: got %b required %b",
               e.name, act, e.ctrl);
    end
    checks++;
    if (retired !== exp_cnt) begin
      errors++;
      $display("FAIL %s retired: got %h required %h", e.name, retired, exp_cnt);
    end
    @(posedge clk);
    #1;
    if (rst) exp_cnt = '0;
`ifdef UC_RETIRE_CNT_EN
    else if (e.cnt) exp_cnt = exp_cnt + 1'b1;
`endif
  endtask

  task automatic test_reset();
    apply("reset_c0", 1'b1, 6'b000100, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("reset_c1", 1'b1, 6'b000100, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("boot",     1'b0, 6'b000100, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("first_run", 1'b0, 6'b000100, 1'b0, 1'b0, c_alu(3'b001), 1'b1);
  endtask

  task automatic test_decode();
    apply("li",       1'b0, 6'b100000, 1'b0, 1'b0, c_li(), 1'b1);
    apply("li_b",     1'b0, 6'b101101, 1'b1, 1'b0, c_li(), 1'b1);
    apply("alu_111",  1'b0, 6'b011110, 1'b1, 1'b0, c_alu(3'b111), 1'b1);
    apply("j",        1'b0, 6'b110000, 1'b0, 1'b0, c_jmp(1'b0), 1'b1);
    apply("nop",      1'b0, 6'b110101, 1'b0, 1'b0, c_jmp(1'b1), 1'b1);
    apply("resume_run_ignored", 1'b0, 6'b010000, 1'b0, 1'b1, c_alu(3'b100), 1'b1);
  endtask

  task automatic test_cond_jump();
    apply("jz_z1",  1'b0, 6'b110001, 1'b1, 1'b0, c_jmp(1'b0), 1'b1);
    apply("jz_z0",  1'b0, 6'b110001, 1'b0, 1'b0, c_jmp(1'b1), 1'b1);
    apply("jnz_z0", 1'b0, 6'b110010, 1'b0, 1'b0, c_jmp(1'b0), 1'b1);
    apply("jnz_z1", 1'b0, 6'b110010, 1'b1, 1'b0, c_jmp(1'b1), 1'b1);
  endtask

  task automatic test_halt_resume();
    apply("halt_decode_resume1", 1'b0, 6'b111111, 1'b0, 1'b1, c_halt_run(), 1'b0);
    for (int i = 0; i < 5; i++)
      apply($sformatf("halt_hold%0d", i), 1'b0, 6'b111111, 1'b0, 1'b0, c_halted(1'b0), 1'b0);
    apply("halt_resume", 1'b0, 6'b111111, 1'b0, 1'b1, c_halted(1'b1), 1'b0);
    apply("after_resume", 1'b0, 6'b001000, 1'b0, 1'b0, c_alu(3'b010), 1'b1);
  endtask

  task automatic test_reset_in_halt();
    apply("enter_halt", 1'b0, 6'b111111, 1'b0, 1'b0, c_halt_run(), 1'b0);
    apply("halted",     1'b0, 6'b111111, 1'b0, 1'b0, c_halted(1'b0), 1'b0);
    apply("reset_in_halt", 1'b1, 6'b111111, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("boot_after_halt", 1'b0, 6'b110101, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("run_after_halt",  1'b0, 6'b110101, 1'b0, 1'b0, c_jmp(1'b1), 1'b1);
  endtask

  task automatic test_counter();
    apply("cnt_reset", 1'b1, 6'b000000, 1'b0, 1'b0, c_boot(), 1'b0);
    apply("cnt_boot",  1'b0, 6'b000000, 1'b0, 1'b0, c_boot(), 1'b0);
    reset  = 1'b0;
    opcode = 6'b000000;
    resume = 1'b0;
    repeat (65535) @(posedge clk);
    #1;
`ifdef UC_RETIRE_CNT_EN
    exp_cnt = 16'hFFFF;
`endif
    apply("cnt_wrap",   1'b0, 6'b000000, 1'b0, 1'b0, c_alu(3'b000), 1'b1);
    apply("cnt_halt",   1'b0, 6'b111111, 1'b0, 1'b0, c_halt_run(), 1'b0);
    apply("cnt_halted", 1'b0, 6'b111111, 1'b0, 1'b0, c_halted(1'b0), 1'b0);
    checks++;
    if (retired !== 16'h0000) begin
      errors++;
      $display("FAIL cnt_final retired: got %h required 0000", retired);
    end
  endtask

  initial begin
    reset  = 1'b1;
    opcode = '0;
    z      = 1'b0;
    resume = 1'b0;
    test_reset();
    test_decode();
    test_cond_jump();
    test_halt_resume();
    test_reset_in_halt();
    test_counter();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
